// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_pkg
//  Description : Shared mode encoding and saturation helper for conv3x3_stream.
//  Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

    typedef enum logic [1:0] {
        MODE_SHARPEN = 2'd0,
        MODE_GAUSS   = 2'd1,
        MODE_EDGE    = 2'd2,
        MODE_PASS    = 2'd3
    } mode_t;

    localparam int c_SAT_W = 32;

    // Clamp a signed value into the unsigned range [0, 2^i_width - 1].
    function automatic logic [c_SAT_W-1:0] saturate(
        input logic signed [c_SAT_W-1:0] i_val,
        input int unsigned               i_width
    );
        logic signed [c_SAT_W-1:0] w_max;
        w_max = $signed((c_SAT_W'(1) << i_width) - c_SAT_W'(1));
        if (i_val < 0) begin
            return '0;
        end else if (i_val > w_max) begin
            return w_max;
        end else begin
            return i_val;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv3x3_stream_if.sv
`default_nettype none
// ============================================================================
//  Module      : conv3x3_stream_if
//  Description : Input and output pixel stream handshakes of conv3x3_stream.
//  Revision    : 1.0 - initial release
// ============================================================================
interface conv3x3_stream_if #(
    parameter int PIXEL_WIDTH = 8
);
    logic                   s_valid;
    logic                   s_ready;
    logic [PIXEL_WIDTH-1:0] s_data;
    logic                   s_sof;
    logic                   m_valid;
    logic                   m_ready;
    logic [PIXEL_WIDTH-1:0] m_data;
    logic                   m_eol;
    logic                   m_eof;

    modport slave (
        input  s_valid, s_data, s_sof, m_ready,
        output s_ready, m_valid, m_data, m_eol, m_eof
    );

    modport master (
        output s_valid, s_data, s_sof, m_ready,
        input  s_ready, m_valid, m_data, m_eol, m_eof
    );
endinterface
`default_nettype wire

// File: rtl/conv_line_buf.sv
`default_nettype none
// ============================================================================
//  Module      : conv_line_buf
//  Description : One-line pixel delay, single address, read-before-write.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_line_buf #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  wire logic             clk,
    input  wire logic             i_we,
    input  wire logic [AW-1:0]    i_addr,
    input  wire logic [WIDTH-1:0] i_wdata,
    output logic      [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Asynchronous read returns the old word in the same cycle as the write.
    assign o_rdata = r_mem[i_addr];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv3x3_stream.sv
`default_nettype none
// ============================================================================
//  Module      : conv3x3_stream
//  Description : Raster-order streaming 3x3 convolution with two line buffers.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv3x3_stream
    import conv_pkg::*;
#(
    parameter int PIXEL_WIDTH = 8,
    parameter int IMG_W       = 640,
    parameter int IMG_H       = 480,
    parameter int ACCW        = PIXEL_WIDTH + 5
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic [1:0]    mode,
    conv3x3_stream_if.slave    bus
);

    localparam int          c_CW       = $clog2(IMG_W);
    localparam int          c_RW       = $clog2(IMG_H);
    localparam int unsigned c_PW       = PIXEL_WIDTH;
    localparam logic [c_CW-1:0] c_COL_LAST = c_CW'(IMG_W - 1);
    localparam logic [c_RW-1:0] c_ROW_LAST = c_RW'(IMG_H - 1);
    localparam logic [c_CW-1:0] c_COL_TWO  = c_CW'(2);
    localparam logic [c_RW-1:0] c_ROW_TWO  = c_RW'(2);

    logic [c_CW-1:0]        r_col;
    logic [c_RW-1:0]        r_row;
    mode_t                  r_mode;
    logic [PIXEL_WIDTH-1:0] r_win [3][3];
    logic                   r_m_valid;
    logic [PIXEL_WIDTH-1:0] r_m_data;
    logic                   r_m_eol;
    logic                   r_m_eof;

    logic                   w_accept;
    logic [c_CW-1:0]        w_col;
    logic [c_RW-1:0]        w_row;
    logic                   w_emit;
    logic                   w_eol;
    logic [PIXEL_WIDTH-1:0] w_lb0_rd;
    logic [PIXEL_WIDTH-1:0] w_lb1_rd;
    logic [PIXEL_WIDTH-1:0] w_tap [3][3];
    logic signed [ACCW-1:0] w_t [3][3];
    logic signed [ACCW-1:0] w_c;
    logic signed [ACCW-1:0] w_edges;
    logic signed [ACCW-1:0] w_corn;
    logic signed [ACCW-1:0] w_acc;
    logic [PIXEL_WIDTH-1:0] w_sat;

    assign bus.s_ready = !r_m_valid || bus.m_ready;
    assign bus.m_valid = r_m_valid;
    assign bus.m_data  = r_m_data;
    assign bus.m_eol   = r_m_eol;
    assign bus.m_eof   = r_m_eof;

    assign w_accept = bus.s_valid && bus.s_ready;
    // s_sof forces the current pixel to the frame origin whatever the counters say.
    assign w_col    = bus.s_sof ? '0 : r_col;
    assign w_row    = bus.s_sof ? '0 : r_row;
    assign w_emit   = (w_row >= c_ROW_TWO) && (w_col >= c_COL_TWO);
    assign w_eol    = (w_col == c_COL_LAST);

    conv_line_buf #(.DEPTH(IMG_W), .WIDTH(PIXEL_WIDTH), .AW(c_CW)) u_lb0 (
        .clk     (clk),
        .i_we    (w_accept),
        .i_addr  (w_col),
        .i_wdata (bus.s_data),
        .o_rdata (w_lb0_rd)
    );

    conv_line_buf #(.DEPTH(IMG_W), .WIDTH(PIXEL_WIDTH), .AW(c_CW)) u_lb1 (
        .clk     (clk),
        .i_we    (w_accept),
        .i_addr  (w_col),
        .i_wdata (w_lb0_rd),
        .o_rdata (w_lb1_rd)
    );

    // The window as it stands after this accept: shifted left with the new column on the right.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_tap[i][0] = r_win[i][1];
            w_tap[i][1] = r_win[i][2];
        end
        w_tap[0][2] = w_lb1_rd;
        w_tap[1][2] = w_lb0_rd;
        w_tap[2][2] = bus.s_data;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                w_t[i][j] = $signed({{(ACCW-PIXEL_WIDTH){1'b0}}, w_tap[i][j]});
            end
        end
    end

    always_comb begin
        w_c     = w_t[1][1];
        w_edges = w_t[0][1] + w_t[1][0] + w_t[1][2] + w_t[2][1];
        w_corn  = w_t[0][0] + w_t[0][2] + w_t[2][0] + w_t[2][2];
        case (r_mode)
            MODE_SHARPEN: w_acc = (w_c <<< 2) + w_c - w_edges;
            MODE_GAUSS:   w_acc = (w_corn + (w_edges <<< 1) + (w_c <<< 2)) >>> 4;
            MODE_EDGE:    w_acc = (w_c <<< 3) - w_corn - w_edges;
            default:      w_acc = w_c;
        endcase
        w_sat = PIXEL_WIDTH'(saturate(c_SAT_W'(w_acc), c_PW));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col  <= '0;
            r_row  <= '0;
            r_mode <= MODE_SHARPEN;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    r_win[i][j] <= '0;
                end
            end
        end else if (w_accept) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    r_win[i][j] <= w_tap[i][j];
                end
            end
            if ((w_col == '0) && (w_row == '0)) begin
                r_mode <= mode_t'(mode);
            end
            if (w_eol) begin
                r_col <= '0;
                r_row <= (w_row == c_ROW_LAST) ? '0 : w_row + 1'b1;
            end else begin
                r_col <= w_col + 1'b1;
                r_row <= w_row;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_eol   <= 1'b0;
            r_m_eof   <= 1'b0;
        end else if (w_accept && w_emit) begin
            r_m_valid <= 1'b1;
            r_m_data  <= w_sat;
            r_m_eol   <= w_eol;
            r_m_eof   <= w_eol && (w_row == c_ROW_LAST);
        end else if (bus.m_ready) begin
            r_m_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv3x3_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv3x3_stream
//  Description : Self-checking bench for conv3x3_stream against an image model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv3x3_stream;

    localparam int PW = 8;
    localparam int W  = 8;
    localparam int H  = 6;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic [1:0] mode = 2'd0;

    conv3x3_stream_if #(.PIXEL_WIDTH(PW)) bus ();

    conv3x3_stream #(
        .PIXEL_WIDTH (PW),
        .IMG_W       (W),
        .IMG_H       (H),
        .ACCW        (PW + 5)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .mode (mode),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        bit eol;
        bit eof;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   img [H][W];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   out_count = 0;
    bit   stall_en  = 1'b0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Output image pixel whose 3x3 neighbourhood ends at (r,c), centre (r-1,c-1).
    function automatic int conv_model(input int r, input int c, input int m);
        int ctr, nsew, corn, res;
        ctr  = img[r-1][c-1];
        nsew = img[r-2][c-1] + img[r][c-1] + img[r-1][c-2] + img[r-1][c];
        corn = img[r-2][c-2] + img[r-2][c] + img[r][c-2] + img[r][c];
        case (m)
            0:       res = 5 * ctr - nsew;
            1:       res = (corn + 2 * nsew + 4 * ctr) / 16;
            2:       res = 8 * ctr - nsew - corn;
            default: res = ctr;
        endcase
        if (res < 0)   res = 0;
        if (res > 255) res = 255;
        return res;
    endfunction

    // Output checker, plus hold-stability while stalled.
    logic          prev_stall = 1'b0;
    logic [PW-1:0] held_d;
    logic          held_eol, held_eof;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_hold", int'({bus.m_valid, bus.m_eol, bus.m_eof, bus.m_data}),
                          int'({1'b1, held_eol, held_eof, held_d}));
                end
                if (bus.m_valid && bus.m_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_output: got data %0d, expected no output", bus.m_data);
                    end else begin
                        cur = exp_q.pop_front();
                        check("out_data", int'(bus.m_data), cur.data);
                        check("out_eol",  int'(bus.m_eol),  int'(cur.eol));
                        check("out_eof",  int'(bus.m_eof),  int'(cur.eof));
                        out_count++;
                    end
                end
                prev_stall = bus.m_valid && !bus.m_ready;
                held_d     = bus.m_data;
                held_eol   = bus.m_eol;
                held_eof   = bus.m_eof;
            end
        end
    end

    initial begin
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.m_ready = stall_en ? 1'($urandom % 2) : 1'b1;
        end
    end

    task automatic send_frame(input int m, input int npix, input bit gaps,
                              input int chg_at, input int new_m, input bit sof_first);
        int r, c, waited;
        for (int idx = 0; idx < npix; idx++) begin
            r = idx / W;
            c = idx % W;
            if (gaps && ($urandom % 4 == 0)) begin
                bus.s_valid = 1'b0;
                repeat (1 + $urandom % 2) begin
                    @(posedge clk);
                    #1;
                end
            end
            mode        = (idx >= chg_at) ? 2'(new_m) : 2'(m);
            bus.s_valid = 1'b1;
            bus.s_data  = PW'(img[r][c]);
            bus.s_sof   = sof_first && (idx == 0);
            waited      = 0;
            forever begin
                @(negedge clk);
                if (bus.s_ready) break;
                waited++;
                if (waited > 1000) begin
                    $display("FAIL accept_timeout: pixel %0d not accepted, expected accept within 1000 cycles", idx);
                    $fatal(1);
                end
            end
            if (r >= 2 && c >= 2) begin
                exp_q.push_back('{conv_model(r, c, m), (c == W-1), (c == W-1) && (r == H-1)});
            end
            @(posedge clk);
            #1;
        end
        bus.s_valid = 1'b0;
        bus.s_sof   = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain_empty", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int m, input bit gaps);
        out_count = 0;
        send_frame(m, W * H, gaps, W * H, m, 1'b1);
        drain();
        check("frame_outputs", out_count, 24);
    endtask

    task automatic fill_random();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = int'($urandom % 256);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_sof   = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_m_valid", int'(bus.m_valid), 0);
        check("rst_m_data",  int'(bus.m_data),  0);
        check("rst_m_eol",   int'(bus.m_eol),   0);
        check("rst_m_eof",   int'(bus.m_eof),   0);
        check("rst_s_ready", int'(bus.s_ready), 1);
        @(posedge clk);
        #1;

        // Constant frame in every mode.
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 100;
        check("pin_const_sharpen", conv_model(2, 2, 0), 100);
        check("pin_const_gauss",   conv_model(2, 2, 1), 100);
        check("pin_const_edge",    conv_model(2, 2, 2), 0);
        check("pin_const_pass",    conv_model(2, 2, 3), 100);
        for (int m = 0; m < 4; m++) run_frame(m, 1'b0);

        // Isolated bright pixel, edge mode.
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 0;
        img[3][3] = 255;
        check("pin_dot_centre",    conv_model(4, 4, 2), 255);
        check("pin_dot_neigh_e",   conv_model(4, 5, 2), 0);
        check("pin_dot_neigh_nw",  conv_model(3, 3, 2), 0);
        run_frame(2, 1'b0);

        // Horizontal ramp.
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = c * 30;
        check("pin_ramp_sharpen", conv_model(3, 4, 0), 90);
        check("pin_ramp_gauss",   conv_model(3, 4, 1), 90);
        run_frame(0, 1'b0);
        run_frame(1, 1'b0);

        // Random images with backpressure and input gaps.
        stall_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            fill_random();
            run_frame(int'($urandom % 4), 1'b1);
        end
        stall_en = 1'b0;

        // Mode change mid-frame only takes effect on the next frame.
        fill_random();
        out_count = 0;
        send_frame(0, W * H, 1'b0, 20, 2, 1'b1);
        drain();
        check("modechg_outputs", out_count, 24);
        run_frame(2, 1'b0);

        // Resync: s_sof after 30 pixels of a frame.
        fill_random();
        send_frame(1, 30, 1'b0, W * H, 1, 1'b1);
        drain();
        fill_random();
        run_frame(0, 1'b0);

        // Reset mid-frame, then a frame without s_sof.
        fill_random();
        send_frame(2, 25, 1'b0, W * H, 2, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("midrst_m_valid", int'(bus.m_valid), 0);
        check("midrst_m_data",  int'(bus.m_data),  0);
        check("midrst_s_ready", int'(bus.s_ready), 1);
        @(posedge clk);
        #1;
        fill_random();
        out_count = 0;
        send_frame(3, W * H, 1'b0, W * H, 3, 1'b0);
        drain();
        check("postrst_outputs", out_count, 24);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
